// File: rtl/demux_router_pkg.sv
// Shared defaults and helpers for the demux_router slice.
package demux_router_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 3;
  localparam int DEF_SEL_W    = 2;
  localparam int DEF_CNT_W    = 8;

  localparam logic [DEF_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Smallest select width that can address every channel (at least 1 bit).
  function automatic int min_sel_w(input int channels);
    int w;
    w = 5;
    for (int i = 4; i >= 1; i--) begin
      if ((1 << i) >= channels) w = i;
    end
    return w;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: captures a word on fill, clears valid on drain.
// A simultaneous fill and drain replaces the word and keeps the slot valid.
module demux_slot
  import demux_router_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_dat,
  input  logic             drain,
  output logic [WIDTH-1:0] q_dat,
  output logic             q_vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_dat <= '0;
      q_vld <= 1'b0;
    end else if (fill) begin
      q_dat <= fill_dat;
      q_vld <= 1'b1;
    end else if (drain) begin
      q_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-N demux with a one-entry slot per channel; 1-cycle latency.
// Out-of-range selects are always consumed, flagged on ERR and counted.
module demux_router
  import demux_router_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [WIDTH-1:0]          I,
  input  logic [SEL_W-1:0]          S,
  input  logic                      I_VALID,
  output logic                      I_READY,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       Q_VALID,
  input  logic [CHANNELS-1:0]       Q_READY,
  output logic                      ERR,
  output logic [CNT_W-1:0]          DROP_CNT
);

  localparam int NSEL = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (SEL_W < min_sel_w(CHANNELS)) begin : g_sel_w_check
    $error("demux_router: SEL_W too narrow for CHANNELS");
  end

  logic [NSEL-1:0] slot_free;
  logic            accept;
  logic            illegal_acc;

  assign accept      = I_VALID && I_READY;
  assign illegal_acc = accept && (int'(S) >= CHANNELS);

  // Unused select codes read as always-free so illegal words are never stalled.
  assign I_READY = slot_free[S];

  for (genvar k = 0; k < NSEL; k++) begin : g_sel
    if (k < CHANNELS) begin : g_ch
      assign slot_free[k] = !Q_VALID[k] || Q_READY[k];

      demux_slot #(.WIDTH(WIDTH)) u_slot (
        .clk      (CLK),
        .rst_n    (RST_N),
        .fill     (accept && (S == SEL_W'(k))),
        .fill_dat (I),
        .drain    (Q_READY[k]),
        .q_dat    (Q[k*WIDTH +: WIDTH]),
        .q_vld    (Q_VALID[k])
      );
    end else begin : g_pad
      assign slot_free[k] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ERR      <= 1'b0;
      DROP_CNT <= '0;
    end else begin
      ERR <= illegal_acc;
      if (illegal_acc && (DROP_CNT != CNT_MAX)) begin
        DROP_CNT <= DROP_CNT + 1'b1;
      end
    end
  end

endmodule
